chebyshev_term_generator: RTL and testbench

- Generates the Chebyshev polynomial terms T_0(x)..T_N(x) for a fixed-point argument x, one term per handshake.
- Uses the three-term recurrence T_{k+1} = 2x·T_k − T_{k−1}.
- Sits directly downstream of the index counter stage in the Chebyshev datapath and takes over the index sequencing internally.
- Each emitted term is tagged with its index k so the downstream coefficient multiply/accumulate stage can select its coefficient.

---
 rtl/chebyshev_term_generator.sv | 148 ++++++++++++++
 tb/tb_chebyshev_term_generator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/chebyshev_term_generator.sv
// rtl/chebyshev_term_generator.sv - Chebyshev polynomial term generator T_0(x)..T_N(x)
//
// Purpose:
//   Emits T_0(x) .. T_N(x) for a signed fixed-point argument x, one term per
//   valid/ready handshake, using T_{k+1} = 2x*T_k - T_{k-1}. Each term is tagged
//   with its index k so a downstream coefficient stage can pick its coefficient.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   sequence request, only accepted in IDLE
//   x_in       in   signed Q(FRAC_BITS) argument, latched on accepted start
//   order      in   highest index N to emit, latched on accepted start
//   busy       out  high from the cycle after an accepted start through DONE
//   out_valid  out  out_data/out_index hold a valid term
//   out_ready  in   downstream accepts the term when out_valid & out_ready
//   out_index  out  index k of the presented term
//   out_data   out  T_k(x), same Q format as x_in
//   done       out  one-cycle pulse after the last term handshake

module chebyshev_term_generator #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 14,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  x_in,
  input  logic [INDEX_WIDTH-1:0] order,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   done
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = 2 * DW + 2;

  localparam logic [DW-1:0] ONE = DW'(1 << FRAC_BITS);

  // Saturation bounds sign-extended to the wide recurrence width.
  localparam logic signed [WW-1:0] SAT_MAX = {{(DW + 3){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(DW + 3){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          x_q, x_d;
  logic [INDEX_WIDTH-1:0] order_q, order_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]          cur_q, cur_d;   // T_k, the term being presented
  logic [DW-1:0]          prev_q, prev_d; // T_{k-1}

  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] prod_shr;
  logic signed [WW-1:0]   wide;
  logic [DW-1:0]          next_term;
  logic                   handshake;

  // Full-precision recurrence; >>> on a signed value rounds toward -inf.
  always_comb begin
    prod     = $signed(x_q) * $signed(cur_q);
    prod_shr = prod >>> FRAC_BITS;
    wide     = ({{2{prod_shr[2*DW-1]}}, prod_shr} <<< 1)
             - {{(DW + 2){prev_q[DW-1]}}, prev_q};
    if (wide > SAT_MAX) begin
      next_term = {1'b0, {(DW - 1){1'b1}}};
    end else if (wide < SAT_MIN) begin
      next_term = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      next_term = wide[DW-1:0];
    end
  end

  assign handshake = (state_q == EMIT) && out_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    order_d = order_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    prev_d  = prev_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          x_d     = x_in;
          order_d = order;
          idx_d   = '0;
          cur_d   = ONE;
          prev_d  = '0;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (idx_q == order_q) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + INDEX_WIDTH'(1);
            prev_d = cur_q;
            // T_1 = x is a base case, not produced by the recurrence.
            cur_d  = (idx_q == '0) ? x_q : next_term;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      order_q <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      order_q <= order_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_index = idx_q;
  assign out_data  = cur_q;

endmodule

// File: tb/tb_chebyshev_term_generator.sv
// tb/tb_chebyshev_term_generator.sv - Self-checking bench for chebyshev_term_generator

module tb_chebyshev_term_generator;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] x_in;
  logic [2:0]  order;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_index;
  logic [15:0] out_data;
  logic        done;

  int checks;
  int errors;

  chebyshev_term_generator #(
    .DATA_WIDTH (16),
    .FRAC_BITS  (14),
    .INDEX_WIDTH(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x_in     (x_in),
    .order    (order),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_data (out_data),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string          name;
    logic [15:0]    x;
    logic [2:0]     ord;
    logic [7:0][15:0] exp;
    int             stall_idx;  // -1 = no backpressure
    int             stall_len;
    bit             poke_start; // pulse start during EMIT and DONE
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_term(input string name, input int k, input logic [15:0] d);
    chk($sformatf("%s valid k%0d", name, k), {31'd0, out_valid}, 32'd1);
    chk($sformatf("%s busy k%0d", name, k), {31'd0, busy}, 32'd1);
    chk($sformatf("%s index k%0d", name, k), {29'd0, out_index}, k);
    chk($sformatf("%s data k%0d", name, k), {16'd0, out_data}, {16'd0, d});
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    start = 1'b1;
    x_in  = v.x;
    order = v.ord;
    @(negedge clock);
    start = 1'b0;
    // Inputs changing after acceptance must have no effect.
    x_in  = ~v.x;
    order = ~v.ord;
    for (int k = 0; k <= int'(v.ord); k++) begin
      start = v.poke_start && (k == 1 || v.ord == 0);
      if (k == v.stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          check_term({v.name, " stall"}, k, v.exp[k]);
          @(negedge clock);
        end
        out_ready = 1'b1;
      end
      check_term(v.name, k, v.exp[k]);
      @(negedge clock);
      start = 1'b0;
    end
    start = v.poke_start;
    chk({v.name, " done pulse"}, {31'd0, done}, 32'd1);
    chk({v.name, " done valid"}, {31'd0, out_valid}, 32'd0);
    chk({v.name, " done busy"}, {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
    chk({v.name, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({v.name, " idle done"}, {31'd0, done}, 32'd0);
    @(negedge clock);
    chk({v.name, " stays idle"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    x_in      = '0;
    order     = '0;
    out_ready = 1'b1;

    vecs[0] = '{"half",     16'h2000, 3'd4, {16'h0, 16'h0, 16'h0, 16'hE000, 16'hC000, 16'hE000, 16'h2000, 16'h4000}, -1, 0, 1'b0};
    vecs[1] = '{"one",      16'h4000, 3'd3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000, 16'h4000, 16'h4000}, -1, 0, 1'b0};
    vecs[2] = '{"minus2",   16'h8000, 3'd2, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h8000, 16'h4000}, -1, 0, 1'b0};
    vecs[3] = '{"stall",    16'h2000, 3'd4, {16'h0, 16'h0, 16'h0, 16'hE000, 16'hC000, 16'hE000, 16'h2000, 16'h4000}, 2, 3, 1'b0};
    vecs[4] = '{"order0",   16'h1234, 3'd0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000}, -1, 0, 1'b1};
    vecs[5] = '{"poke",     16'h2000, 3'd4, {16'h0, 16'h0, 16'h0, 16'hE000, 16'hC000, 16'hE000, 16'h2000, 16'h4000}, -1, 0, 1'b1};
    vecs[6] = '{"zero_max", 16'h0000, 3'd7, {16'h0, 16'hC000, 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 16'h4000}, 5, 1, 1'b0};
    vecs[7] = '{"floor",    16'h0001, 3'd3, {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFD, 16'hC000, 16'h0001, 16'h4000}, -1, 0, 1'b0};

    repeat (2) @(negedge clock);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset index", {29'd0, out_index}, 32'd0);
    chk("reset data", {16'd0, out_data}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Negative saturation: T_3 for x = -2.0 clamps to -32768.
    vecs[0] = '{"negsat", 16'h8000, 3'd3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h7FFF, 16'h8000, 16'h4000}, -1, 0, 1'b0};
    run_vec(vecs[0]);

    // Reset while index 2 is presented, then a fresh sequence with a new x.
    @(negedge clock);
    start = 1'b1;
    x_in  = 16'h2000;
    order = 3'd4;
    @(negedge clock);
    start = 1'b0;
    check_term("abort", 0, 16'h4000);
    @(negedge clock);
    check_term("abort", 1, 16'h2000);
    @(negedge clock);
    check_term("abort", 2, 16'hE000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort valid", {31'd0, out_valid}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort index", {29'd0, out_index}, 32'd0);
    chk("abort data", {16'd0, out_data}, 32'd0);
    @(negedge clock);
    chk("abort stays idle", {30'd0, busy, out_valid}, 32'd0);
    vecs[1] = '{"restart", 16'h4000, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000}, -1, 0, 1'b0};
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
